// File: rtl/sobel_pkg.sv
// Shared types, widths and helpers for the Sobel edge unit.
// Gradients are signed 11-bit, magnitudes unsigned 11-bit; counters cover a 640x480 frame.
package sobel_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int DEF_OUT_COLS = 638;
  localparam int DEF_OUT_ROWS = 478;
  localparam int PIX_W        = 8;
  localparam int GRAD_W       = 11;
  localparam int MAG_W        = 11;
  localparam int CNT_W        = 19;
  localparam int STAGES       = 3;

  // |g| always fits in MAG_W because |g| <= 1020.
  function automatic logic [MAG_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    return g[GRAD_W-1] ? MAG_W'(-g) : MAG_W'(g);
  endfunction
endpackage

// File: rtl/sobel_edge_unit_if.sv
// Window-in / edge-bit-out handshake bundle of the Sobel edge unit.
interface sobel_edge_unit_if;
  import sobel_pkg::*;

  logic                 frame_start;
  logic                 win_valid;
  logic [9*PIX_W-1:0]   win;
  logic [MAG_W-1:0]     threshold;
  logic                 out_full;
  logic                 win_ready;
  logic                 edge_pixel;
  logic                 out_en;
  logic                 img_done;
  logic                 busy;

  modport master (
    output frame_start, win_valid, win, threshold, out_full,
    input  win_ready, edge_pixel, out_en, img_done, busy
  );
  modport slave (
    input  frame_start, win_valid, win, threshold, out_full,
    output win_ready, edge_pixel, out_en, img_done, busy
  );
endinterface

// File: rtl/sobel_gradient.sv
// Combinational Sobel Gx/Gy from a row-major 3x3 window of unsigned pixels.
module sobel_gradient
  import sobel_pkg::*;
(
    input  logic [9*PIX_W-1:0]        win,
    output logic signed [GRAD_W-1:0]  gx,
    output logic signed [GRAD_W-1:0]  gy
);
    logic [GRAD_W-1:0] p [9];

    always_comb begin
        for (int i = 0; i < 9; i++) p[i] = GRAD_W'(win[i*PIX_W +: PIX_W]);
    end

    // Each weighted column/row sum is at most 1020, so the difference fits signed 11-bit.
    assign gx = $signed((p[2] + (p[5] << 1) + p[8]) - (p[0] + (p[3] << 1) + p[6]));
    assign gy = $signed((p[6] + (p[7] << 1) + p[8]) - (p[0] + (p[1] << 1) + p[2]));
endmodule

// File: rtl/sobel_edge_unit.sv
// Three-stage Sobel edge detector with frame accounting and a global stall from out_full.
// Stage 1: gradients, stage 2: |Gx|+|Gy|, stage 3: threshold compare.
module sobel_edge_unit
  import sobel_pkg::*;
#(
    parameter int OUT_COLS = DEF_OUT_COLS,
    parameter int OUT_ROWS = DEF_OUT_ROWS
)(
    input  logic              clk,
    input  logic              n_rst,
    sobel_edge_unit_if.slave  bus
);
    localparam logic [CNT_W-1:0] TOTAL = CNT_W'(OUT_COLS * OUT_ROWS);

    state_t                    state;
    logic [CNT_W-1:0]          in_cnt, out_cnt;
    logic                      done_q, busy_q;
    logic [STAGES:1]           vld_pipe;
    logic signed [GRAD_W-1:0]  gx, gy, s1_gx, s1_gy;
    logic [MAG_W-1:0]          s1_thr, s2_thr, s2_mag;
    logic                      s3_edge;
    logic                      accept, advance;

    sobel_gradient u_grad (.win(bus.win), .gx(gx), .gy(gy));

    assign advance        = !bus.out_full;
    assign bus.win_ready  = (state == RUN) && !bus.out_full && (in_cnt < TOTAL);
    assign accept         = bus.win_valid && bus.win_ready;
    assign bus.out_en     = vld_pipe[STAGES] && !bus.out_full;
    assign bus.edge_pixel = s3_edge;
    assign bus.img_done   = done_q;
    assign bus.busy       = busy_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            in_cnt  <= '0;
            out_cnt <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            if (bus.out_en) out_cnt <= out_cnt + CNT_W'(1);
            case (state)
                IDLE, DONE: if (bus.frame_start) begin
                    state   <= RUN;
                    in_cnt  <= '0;
                    out_cnt <= '0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b1;
                end
                RUN: if (accept) begin
                    in_cnt <= in_cnt + CNT_W'(1);
                    if (in_cnt + CNT_W'(1) == TOTAL) state <= DRAIN;
                end
                DRAIN: if (bus.out_en && (out_cnt + CNT_W'(1) == TOTAL)) begin
                    state  <= DONE;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Whole pipeline freezes while out_full is high; stage 3 is forced to 0 when its slot is empty.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_pipe <= '0;
            s1_gx    <= '0;
            s1_gy    <= '0;
            s1_thr   <= '0;
            s2_mag   <= '0;
            s2_thr   <= '0;
            s3_edge  <= 1'b0;
        end else if (advance) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            s1_gx    <= gx;
            s1_gy    <= gy;
            s1_thr   <= bus.threshold;
            s2_mag   <= abs_grad(s1_gx) + abs_grad(s1_gy);
            s2_thr   <= s1_thr;
            s3_edge  <= vld_pipe[2] && (s2_mag > s2_thr);
        end
    end
endmodule

// File: tb/tb_sobel_edge_unit.sv
// Self-checking bench: directed corner cases plus randomized frames against an arithmetic Sobel model.
module tb_sobel_edge_unit;
    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    sobel_edge_unit_if bus();
    sobel_edge_unit #(.OUT_COLS(4), .OUT_ROWS(2)) dut (.clk(clk), .n_rst(n_rst), .bus(bus.slave));

    int total = 0;
    int bad   = 0;
    logic [71:0] win_q[$];
    logic [10:0] thr_q[$];
    logic        got_q[$];
    int          full_pct, valid_pct;
    bit          timed_out;

    function automatic int ref_mag(input logic [71:0] w);
        int p[9];
        int gx, gy;
        for (int i = 0; i < 9; i++) p[i] = int'(w[i*8 +: 8]);
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    endfunction

    function automatic logic ref_edge(input logic [71:0] w, input logic [10:0] thr);
        return ref_mag(w) > int'(thr);
    endfunction

    function automatic logic [71:0] rand_win();
        logic [71:0] w;
        for (int i = 0; i < 9; i++) begin
            case ($urandom_range(0, 2))
                0:       w[i*8 +: 8] = 8'd0;
                1:       w[i*8 +: 8] = 8'd255;
                default: w[i*8 +: 8] = 8'($urandom);
            endcase
        end
        return w;
    endfunction

    function automatic logic [10:0] rand_thr(input logic [71:0] w);
        int m;
        m = ref_mag(w);
        if ($urandom_range(0, 1) == 0) return 11'($urandom_range(0, 2047));
        m = m + int'($urandom_range(0, 2)) - 1;
        return 11'(m < 0 ? 0 : m);
    endfunction

    function automatic logic [71:0] edge_win(input bit max_case);
        logic [71:0] w;
        for (int i = 0; i < 9; i++) begin
            if (max_case) w[i*8 +: 8] = (i == 0 || i == 1 || i == 2 || i == 3 || i == 6) ? 8'd0 : 8'd255;
            else          w[i*8 +: 8] = (i == 0 || i == 3 || i == 6) ? 8'd0 : 8'd255;
        end
        return w;
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle;
        bus.frame_start = 1'b0;
        bus.win_valid   = 1'b0;
        bus.win         = '0;
        bus.threshold   = '0;
        bus.out_full    = 1'b0;
    endtask

    task automatic do_reset;
        drive_idle();
        n_rst = 1'b0;
        repeat (2) tick();
        n_rst = 1'b1;
        tick();
    endtask

    task automatic start_frame;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    // Feeds win_q/thr_q with random valid gaps and back-pressure, collecting emitted edge bits.
    task automatic run_stream(input int budget);
        int idx;
        idx = 0;
        got_q.delete();
        timed_out = 1'b0;
        for (int c = 0; c < budget; c++) begin
            bus.win_valid = (idx < win_q.size()) && ($urandom_range(0, 99) < valid_pct);
            if (idx < win_q.size()) begin
                bus.win       = win_q[idx];
                bus.threshold = thr_q[idx];
            end
            bus.out_full = ($urandom_range(0, 99) < full_pct);
            #1;
            if (bus.out_en) got_q.push_back(bus.edge_pixel);
            if (bus.win_valid && bus.win_ready) idx++;
            tick();
            if (got_q.size() >= win_q.size()) begin
                drive_idle();
                return;
            end
        end
        timed_out = 1'b1;
        drive_idle();
    endtask

    task automatic test_reset;
        drive_idle();
        n_rst = 1'b0;
        #3;
        total++;
        if ({bus.win_ready, bus.edge_pixel, bus.out_en, bus.img_done, bus.busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=00000",
                     {bus.win_ready, bus.edge_pixel, bus.out_en, bus.img_done, bus.busy});
        end
        tick();
        n_rst = 1'b1;
        bus.win_valid = 1'b1;
        tick();
        #1;
        total++;
        if ({bus.win_ready, bus.out_en, bus.img_done, bus.busy} !== 4'b0) begin
            bad++;
            $display("FAIL idle_after_reset got=%b exp=0000",
                     {bus.win_ready, bus.out_en, bus.img_done, bus.busy});
        end
        drive_idle();
    endtask

    task automatic test_zero_latency;
        logic [2:0] seen;
        do_reset();
        start_frame();
        bus.win_valid = 1'b1;
        bus.win       = '0;
        bus.threshold = '0;
        #1;
        total++;
        if ({bus.win_ready, bus.busy} !== 2'b11) begin
            bad++;
            $display("FAIL run_ready got=%b exp=11", {bus.win_ready, bus.busy});
        end
        tick();
        bus.win_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            seen[k] = bus.out_en;
            if (k == 2) begin
                total++;
                if (bus.edge_pixel !== 1'b0) begin
                    bad++;
                    $display("FAIL zero_edge got=%b exp=0", bus.edge_pixel);
                end
            end
            tick();
        end
        total++;
        if (seen !== 3'b100) begin
            bad++;
            $display("FAIL zero_latency got=%b exp=100", seen);
        end
        #1;
        total++;
        if (bus.out_en !== 1'b0) begin
            bad++;
            $display("FAIL single_strobe got=%b exp=0", bus.out_en);
        end
    endtask

    task automatic test_threshold_boundary;
        do_reset();
        start_frame();
        win_q = '{edge_win(0), edge_win(0)};
        thr_q = '{11'd1019, 11'd1020};
        full_pct = 0; valid_pct = 100;
        run_stream(40);
        total++;
        if (timed_out || got_q.size() != 2) begin
            bad++;
            $display("FAIL thr_count got=%0d exp=2", got_q.size());
        end else begin
            total++;
            if ({got_q[0], got_q[1]} !== 2'b10) begin
                bad++;
                $display("FAIL thr_boundary got=%b exp=10", {got_q[0], got_q[1]});
            end
        end
    endtask

    task automatic test_max_mag;
        do_reset();
        start_frame();
        win_q = '{edge_win(1), edge_win(1)};
        thr_q = '{11'd1529, 11'd1530};
        full_pct = 0; valid_pct = 100;
        run_stream(40);
        total++;
        if (timed_out || got_q.size() != 2) begin
            bad++;
            $display("FAIL max_count got=%0d exp=2", got_q.size());
        end else begin
            total++;
            if ({got_q[0], got_q[1]} !== 2'b10) begin
                bad++;
                $display("FAIL max_mag got=%b exp=10", {got_q[0], got_q[1]});
            end
        end
    endtask

    task automatic test_stall;
        logic [71:0] w[3];
        logic [10:0] t[3];
        logic        e[3];
        int          stall_bad;
        do_reset();
        start_frame();
        for (int k = 0; k < 3; k++) begin
            w[k] = rand_win();
            t[k] = rand_thr(w[k]);
            e[k] = ref_edge(w[k], t[k]);
            bus.win_valid = 1'b1; bus.win = w[k]; bus.threshold = t[k];
            #1;
            total++;
            if (bus.win_ready !== 1'b1) begin
                bad++;
                $display("FAIL stall_feed got=%b exp=1", bus.win_ready);
            end
            tick();
        end
        bus.win = rand_win();
        bus.out_full = 1'b1;
        stall_bad = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (bus.out_en !== 1'b0 || bus.win_ready !== 1'b0) stall_bad++;
            tick();
        end
        total++;
        if (stall_bad != 0) begin
            bad++;
            $display("FAIL stall_hold got=%0d bad cycles exp=0", stall_bad);
        end
        drive_idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (bus.out_en !== 1'b1 || bus.edge_pixel !== e[k]) begin
                bad++;
                $display("FAIL stall_release[%0d] got=en%b/px%b exp=en1/px%b", k, bus.out_en, bus.edge_pixel, e[k]);
            end
            tick();
        end
        #1;
        total++;
        if (bus.out_en !== 1'b0) begin
            bad++;
            $display("FAIL stall_no_dup got=%b exp=0", bus.out_en);
        end
    endtask

    task automatic test_frame_done;
        int extra;
        int mism;
        do_reset();
        start_frame();
        win_q.delete(); thr_q.delete();
        for (int k = 0; k < 8; k++) begin
            win_q.push_back(rand_win());
            thr_q.push_back(rand_thr(win_q[k]));
        end
        full_pct = 30; valid_pct = 70;
        run_stream(400);
        total++;
        if (timed_out || got_q.size() != 8) begin
            bad++;
            $display("FAIL frame_count got=%0d exp=8", got_q.size());
        end else begin
            mism = 0;
            for (int k = 0; k < 8; k++) if (got_q[k] !== ref_edge(win_q[k], thr_q[k])) mism++;
            total++;
            if (mism != 0) begin
                bad++;
                $display("FAIL frame_data got=%0d wrong pixels exp=0", mism);
            end
        end
        total++;
        if ({bus.img_done, bus.busy} !== 2'b10) begin
            bad++;
            $display("FAIL frame_done got=%b exp=10", {bus.img_done, bus.busy});
        end
        bus.win_valid = 1'b1;
        bus.win = rand_win();
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (bus.win_ready !== 1'b0 || bus.out_en !== 1'b0 || bus.img_done !== 1'b1) extra++;
            tick();
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL done_quiet got=%0d bad cycles exp=0", extra);
        end
        bus.win_valid = 1'b0;
        start_frame();
        #1;
        total++;
        if ({bus.img_done, bus.busy, bus.win_ready} !== 3'b011) begin
            bad++;
            $display("FAIL restart got=%b exp=011", {bus.img_done, bus.busy, bus.win_ready});
        end
    endtask

    task automatic test_random_frames;
        logic [71:0] w[8];
        logic [10:0] t[8];
        logic        exp_q[$];
        int          acc, outs, ready_bad, out_bad;
        logic        exp_ready;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 8; k++) begin
                w[k] = rand_win();
                t[k] = rand_thr(w[k]);
            end
            start_frame();
            exp_q.delete();
            acc = 0; outs = 0; ready_bad = 0; out_bad = 0;
            for (int c = 0; c < 400 && outs < 8; c++) begin
                bus.win_valid = (acc < 8) && ($urandom_range(0, 99) < 80);
                bus.win       = w[acc < 8 ? acc : 7];
                bus.threshold = t[acc < 8 ? acc : 7];
                bus.out_full  = ($urandom_range(0, 99) < 25);
                #1;
                exp_ready = !bus.out_full && (acc < 8);
                if (bus.win_ready !== exp_ready) ready_bad++;
                if (bus.out_en) begin
                    if (bus.out_full || exp_q.size() == 0 || bus.edge_pixel !== exp_q[0]) out_bad++;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    outs++;
                end
                if (bus.win_valid && bus.win_ready) begin
                    exp_q.push_back(ref_edge(w[acc], t[acc]));
                    acc++;
                end
                tick();
            end
            drive_idle();
            #1;
            total++;
            if (ready_bad != 0 || out_bad != 0 || outs != 8 || bus.img_done !== 1'b1) begin
                bad++;
                $display("FAIL random_frame[%0d] got=ready_bad%0d/out_bad%0d/outs%0d/done%b exp=0/0/8/1",
                         f, ready_bad, out_bad, outs, bus.img_done);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int leak;
        do_reset();
        start_frame();
        for (int k = 0; k < 3; k++) begin
            bus.win_valid = 1'b1; bus.win = rand_win(); bus.threshold = 11'd0;
            tick();
        end
        #2;
        n_rst = 1'b0;
        #1;
        total++;
        if ({bus.win_ready, bus.edge_pixel, bus.out_en, bus.img_done, bus.busy} !== 5'b0) begin
            bad++;
            $display("FAIL midreset_outputs got=%b exp=00000",
                     {bus.win_ready, bus.edge_pixel, bus.out_en, bus.img_done, bus.busy});
        end
        tick();
        n_rst = 1'b1;
        leak = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (bus.out_en || bus.win_ready || bus.busy) leak++;
            tick();
        end
        total++;
        if (leak != 0) begin
            bad++;
            $display("FAIL midreset_quiet got=%0d bad cycles exp=0", leak);
        end
        start_frame();
        #1;
        total++;
        if ({bus.win_ready, bus.busy} !== 2'b11) begin
            bad++;
            $display("FAIL midreset_restart got=%b exp=11", {bus.win_ready, bus.busy});
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_threshold_boundary();
        test_max_mag();
        test_stall();
        test_frame_done();
        test_random_frames();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sobel_edge_unit.md
SOBEL_EDGE_UNIT -- requirements
Module: sobel_edge_unit

Interface
REQ-001 SHALL have parameter OUT_COLS, default 638, meaning edge pixels per output row.
REQ-002 SHALL have parameter OUT_ROWS, default 478, meaning output rows per frame.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 frame_start  input  1  one-cycle pulse that begins a frame.
REQ-006 win_valid  input  1  a 3x3 window is presented on win.
REQ-007 win  input  72  nine 8-bit unsigned pixels p0..p8, row-major, p0 at [7:0].
REQ-008 threshold  input  11  edge threshold, sampled at window acceptance.
REQ-009 out_full  input  1  downstream packer is full; stall request.
REQ-010 win_ready  output  1  block accepts the window this cycle.
REQ-011 edge_pixel  output  1  edge decision bit, valid while out_en is high.
REQ-012 out_en  output  1  one-cycle strobe per emitted edge_pixel.
REQ-013 img_done  output  1  frame complete, level.
REQ-014 busy  output  1  high in RUN or DRAIN.

Function
REQ-015 States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + frame_start -> RUN, clearing both counters.
- frame_start in RUN/DRAIN is ignored.
REQ-016 Acceptance occurs on a cycle with win_valid && win_ready.
- win_ready = (state==RUN) && !out_full && (in_cnt < OUT_COLS*OUT_ROWS).
REQ-017 in_cnt and out_cnt are 19-bit counters.
- in_cnt increments on acceptance.
- out_cnt increments on out_en.
REQ-018 Transitions on count completion:
- RUN -> DRAIN on the acceptance that makes in_cnt = OUT_COLS*OUT_ROWS.
- DRAIN -> DONE on the out_en that makes out_cnt equal to that total.
- A 1x1 frame passes through both transitions normally.
REQ-019 Stage 1 (registered) computes two signed 11-bit gradients:
- Gx = (p2+2p5+p8)-(p0+2p3+p6).
- Gy = (p6+2p7+p8)-(p0+2p1+p2).
- threshold is carried alongside.
REQ-020 Stage 2 (registered) computes mag = |Gx|+|Gy| as unsigned 11-bit, max 2040, with no overflow.
REQ-021 Stage 3 (registered) sets edge_pixel = (mag > threshold), strictly greater.
REQ-022 Each stage carries a valid bit.
- The whole pipeline advances only when out_full is low.
- When out_full is high, all stage registers and valids hold.
REQ-023 out_en = s3_valid && !out_full.
- Each accepted window yields exactly one out_en.
- Output order equals acceptance order; the block is agnostic to snake traversal.
REQ-024 Latency: with out_full low, out_en rises 3 cycles after the acceptance edge, and throughput is 1 pixel/cycle.
REQ-025 If out_full rises in the same cycle as a pending output, out_en stays low and edge_pixel holds until out_full falls.
REQ-026 img_done is high only in DONE.
- It stays high until frame_start.
- On that frame_start it falls in the same cycle the state enters RUN.
REQ-027 win_valid while win_ready is low is not consumed; the source holds win.
REQ-028 edge_pixel is 0 whenever s3_valid is low.

Reset
REQ-029 Asynchronous reset values:
- state = IDLE.
- in_cnt = out_cnt = 0.
- All stage valids = 0, data registers = 0.
- win_ready = 0, edge_pixel = 0, out_en = 0, img_done = 0, busy = 0.
REQ-030 Reset asserted mid-frame discards all in-flight pixels, and no out_en follows release until a new frame_start.

Structure
REQ-031 A shared package sobel_pkg holds:
- the state enum type;
- OUT_COLS/OUT_ROWS defaults;
- PIX_W=8, GRAD_W=11, MAG_W=11, CNT_W=19.
REQ-032 One sub-module, sobel_gradient, holds the combinational Gx/Gy computation from the 72-bit window, instantiated ahead of stage 1.
REQ-033 No memories; all state is flip-flops.

Verification
REQ-034 All-zero window, threshold=0 -> mag=0, edge_pixel=0 with out_en 3 cycles later.
REQ-035 Threshold boundary, window p0=p3=p6=0 and others 255:
- Gx=1020, Gy=0.
- threshold=1019 -> edge_pixel=1; threshold=1020 -> edge_pixel=0.
REQ-036 Maximum magnitude and sign: p0=p1=p2=p3=p6=0, others 255 -> Gx=765, Gy=765, mag=1530; threshold=1529 -> edge_pixel=1.
REQ-037 Stall: out_full high for 5 cycles with 3 pixels in flight.
- No out_en and win_ready=0 during the stall.
- After release, 3 consecutive out_en in original order, with no loss or duplicate.
REQ-038 Frame completion with OUT_COLS=4, OUT_ROWS=2:
- After 8 acceptances win_ready stays 0.
- Exactly 8 out_en occur, then img_done=1.
- frame_start then clears img_done and restarts.
REQ-039 Reset mid-frame: n_rst low after 3 of 8 acceptances.
- All outputs return to reset values immediately.
- After release, no out_en occurs until frame_start.
